// File: rtl/bcd_dabble_engine.sv
// Sequential shift-and-add-3 binary-to-BCD converter with held, blanking-aware results.
// Optional BCD_AUTO_CONVERT_EN: start a conversion whenever i_Binary differs from the last one.
module bcd_dabble_engine #(
  parameter int unsigned BIN_WIDTH = 12,
  parameter int unsigned DIGITS    = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic                  i_Start,
  input  logic [BIN_WIDTH-1:0]  i_Binary,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic [4*DIGITS-1:0]   o_BCD,
  output logic                  o_Overflow,
  output logic [DIGITS-1:0]     o_Digit_En
);

  localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);
  localparam int unsigned BcdW = 4 * DIGITS;

  typedef enum logic [1:0] {StIdle, StConvert, StDone} state_e;

  state_e               state_q;
  logic [BIN_WIDTH-1:0] shift_q;
  logic [BcdW-1:0]      scratch_q;
  logic                 ovf_q;
  logic [CntW-1:0]      cnt_q;

  logic [BcdW-1:0]      adjusted;
  logic [BcdW-1:0]      result_bcd;
  logic [DIGITS-1:0]    result_en;
  logic                 start_req;

`ifdef BCD_AUTO_CONVERT_EN
  logic [BIN_WIDTH-1:0] last_q;
  assign start_req = i_Start || (i_Binary != last_q);
`else
  assign start_req = i_Start;
`endif

  // Per-digit add-3 with no inter-digit carry
  always_comb begin
    adjusted = scratch_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        adjusted[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    result_bcd = ovf_q ? {DIGITS{4'h9}} : scratch_q;
    result_en  = '0;
    result_en[DIGITS-1] = |result_bcd[BcdW-1 -: 4];
    for (int k = int'(DIGITS) - 2; k >= 0; k--) begin
      result_en[k] = result_en[k+1] | (|result_bcd[4*k +: 4]);
    end
    result_en[0] = 1'b1;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      scratch_q  <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      o_Busy     <= 1'b0;
      o_Done     <= 1'b0;
      o_BCD      <= '0;
      o_Overflow <= 1'b0;
      o_Digit_En <= DIGITS'(1);
`ifdef BCD_AUTO_CONVERT_EN
      last_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          o_Done <= 1'b0;
          if (start_req) begin
            shift_q   <= i_Binary;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= CntW'(BIN_WIDTH);
            o_Busy    <= 1'b1;
            state_q   <= StConvert;
`ifdef BCD_AUTO_CONVERT_EN
            last_q    <= i_Binary;
`endif
          end
        end
        StConvert: begin
          // {scratch, shift} shifts left; a 1 leaving the scratch top means too many digits
          scratch_q <= {adjusted[BcdW-2:0], shift_q[BIN_WIDTH-1]};
          shift_q   <= shift_q << 1;
          if (adjusted[BcdW-1]) begin
            ovf_q <= 1'b1;
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          o_BCD      <= result_bcd;
          o_Overflow <= ovf_q;
          o_Digit_En <= result_en;
          o_Done     <= 1'b1;
          o_Busy     <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_dabble_engine.sv
// Scoreboard bench for bcd_dabble_engine: a 12-bit and a 14-bit instance, 4 digits each.
module tb_bcd_dabble_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b;
  logic [11:0] bin_a;
  logic [13:0] bin_b;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [15:0] bcd_a, bcd_b;
  logic [3:0]  en_a, en_b;

  bcd_dabble_engine #(.BIN_WIDTH(12), .DIGITS(4)) dut_a (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start_a), .i_Binary(bin_a),
    .o_Busy(busy_a), .o_Done(done_a), .o_BCD(bcd_a), .o_Overflow(ovf_a), .o_Digit_En(en_a)
  );

  bcd_dabble_engine #(.BIN_WIDTH(14), .DIGITS(4)) dut_b (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start_b), .i_Binary(bin_b),
    .o_Busy(busy_b), .o_Done(done_b), .o_BCD(bcd_b), .o_Overflow(ovf_b), .o_Digit_En(en_b)
  );

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  en;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every o_Done must match the oldest outstanding expectation
  always @(posedge clk) begin
    #1;
    if (done_a === 1'b1) begin
      if (q_a.size() == 0) fail_now("dut_a unexpected o_Done");
      else begin
        ea = q_a.pop_front();
        chk("dut_a o_BCD", bcd_a, ea.bcd);
        chk("dut_a o_Overflow", ovf_a, ea.ovf);
        chk("dut_a o_Digit_En", en_a, ea.en);
      end
    end
    if (done_b === 1'b1) begin
      if (q_b.size() == 0) fail_now("dut_b unexpected o_Done");
      else begin
        eb = q_b.pop_front();
        chk("dut_b o_BCD", bcd_b, eb.bcd);
        chk("dut_b o_Overflow", ovf_b, eb.ovf);
        chk("dut_b o_Digit_En", en_b, eb.en);
      end
    end
  end

  // Pulse start for one edge; leaves time at accepting edge + 1
  task automatic issue(input bit sel, input logic [13:0] v, input bit push,
                       input logic [15:0] bcd, input logic ovf, input logic [3:0] en);
    exp_t e;
    e.bcd = bcd;
    e.ovf = ovf;
    e.en  = en;
    @(negedge clk);
    if (sel) begin
      start_b = 1'b1;
      bin_b   = v;
      if (push) q_b.push_back(e);
    end else begin
      start_a = 1'b1;
      bin_a   = v[11:0];
      if (push) q_a.push_back(e);
    end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input string name);
    int n = 0;
    while ((sel ? done_b : done_a) !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if ((sel ? done_b : done_a) !== 1'b1) fail_now({name, " timeout waiting for o_Done"});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt, done_at, held_ok;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset o_BCD a", bcd_a, 16'h0000);
    chk("reset o_Digit_En a", en_a, 4'b0001);
    chk("reset o_Busy a", busy_a, 1'b0);
    chk("reset o_Done a", done_a, 1'b0);
    chk("reset o_Overflow b", ovf_b, 1'b0);
    chk("reset o_Digit_En b", en_b, 4'b0001);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef BCD_AUTO_CONVERT_EN
    repeat (5) @(posedge clk);
    #1;
    chk("auto idle with unchanged input", busy_a, 1'b0);
    @(negedge clk);
    bin_a = 12'd321;
    q_a.push_back('{bcd: 16'h0321, ovf: 1'b0, en: 4'b0111});
    @(posedge clk);
    #1;
    chk("auto start busy", busy_a, 1'b1);
    wait_done(1'b0, "auto 321");
    repeat (30) @(posedge clk);
    #1;
    chk("auto stays idle", busy_a, 1'b0);
    chk("auto held o_BCD", bcd_a, 16'h0321);
`else
    // 4095: busy for BIN_WIDTH+1 samples, o_Done at the BIN_WIDTH+1-th edge after acceptance
    issue(1'b0, 14'd4095, 1'b1, 16'h4095, 1'b0, 4'b1111);
    busy_cnt = int'(busy_a); done_cnt = 0; done_at = 0; held_ok = 1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      busy_cnt += int'(busy_a);
      done_cnt += int'(done_a);
      if (done_a && done_at == 0) done_at = n;
      if (n < 13 && bcd_a !== 16'h0000) held_ok = 0;
    end
    chk("busy cycle count", busy_cnt, 13);
    chk("done latency edges", done_at, 13);
    chk("done pulse count", done_cnt, 1);
    chk("o_BCD stable during conversion", held_ok, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("o_BCD held in idle", bcd_a, 16'h4095);

    issue(1'b0, 14'd0, 1'b1, 16'h0000, 1'b0, 4'b0001);
    wait_done(1'b0, "zero");
    repeat (4) @(posedge clk);
    issue(1'b0, 14'd5, 1'b1, 16'h0005, 1'b0, 4'b0001);
    repeat (4) @(posedge clk);
    #1;
    chk("zero held while converting 5", bcd_a, 16'h0000);
    wait_done(1'b0, "five");

    issue(1'b1, 14'd10000, 1'b1, 16'h9999, 1'b1, 4'b1111);
    wait_done(1'b1, "10000");
    repeat (5) @(posedge clk);
    #1;
    chk("overflow held", ovf_b, 1'b1);
    issue(1'b1, 14'd9999, 1'b1, 16'h9999, 1'b0, 4'b1111);
    wait_done(1'b1, "9999");

    // Start during busy is dropped; changing i_Binary in flight has no effect
    issue(1'b0, 14'd1234, 1'b1, 16'h1234, 1'b0, 4'b1111);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = 12'd777;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    wait_done(1'b0, "1234");
    repeat (20) @(posedge clk);
    #1;
    chk("ignored start leaves idle", busy_a, 1'b0);
    chk("1234 held", bcd_a, 16'h1234);
    issue(1'b0, 14'd777, 1'b1, 16'h0777, 1'b0, 4'b0111);
    wait_done(1'b0, "777");

    // Reset mid-conversion: immediate clear, no o_Done
    issue(1'b0, 14'd2048, 1'b0, 16'h0000, 1'b0, 4'b0001);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort o_Busy", busy_a, 1'b0);
    chk("abort o_Done", done_a, 1'b0);
    chk("abort o_BCD", bcd_a, 16'h0000);
    chk("abort o_Digit_En", en_a, 4'b0001);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("post-abort idle", busy_a, 1'b0);
    issue(1'b0, 14'd100, 1'b1, 16'h0100, 1'b0, 4'b0111);
    wait_done(1'b0, "100");
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("dut_a expectations drained", q_a.size(), 0);
    chk("dut_b expectations drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
